// File: rtl/spi_xip_pkg.sv
// Shared definitions for the SPI execute-in-place bridge: SPI register map,
// CTRL bit positions, flash READ opcode and the sequencer state encoding.
package spi_xip_pkg;

    localparam logic [4:0] REG_RX0     = 5'h00;
    localparam logic [4:0] REG_TX1     = 5'h04;
    localparam logic [4:0] REG_CTRL    = 5'h10;
    localparam logic [4:0] REG_DIVIDER = 5'h14;
    localparam logic [4:0] REG_SS      = 5'h18;

    localparam int CTRL_GO_BIT     = 8;
    localparam int CTRL_TX_NEG_BIT = 10;
    localparam int CTRL_ASS_BIT    = 13;

    localparam logic [6:0] XIP_CHAR_LEN  = 7'd64;
    localparam logic [7:0] FLASH_READ_OP = 8'h03;

    // Opcode + 24-bit address + 32 data bits shifted in one 64-bit character.
    localparam logic [31:0] XIP_CTRL = (32'h1 << CTRL_ASS_BIT)
                                     | (32'h1 << CTRL_TX_NEG_BIT)
                                     | (32'h1 << CTRL_GO_BIT)
                                     | {25'd0, XIP_CHAR_LEN};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ERR,
        ST_PASS,
        ST_WR_TX1,
        ST_WR_DIV,
        ST_WR_SS,
        ST_WR_CTRL,
        ST_POLL,
        ST_RD_RX,
        ST_WR_SSCLR,
        ST_RESP
    } xip_state_e;

    // Flash returns the first byte in the most significant lane of RX0.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_xip_apb_mst.sv
// Single-access APB master: a start pulse launches one SETUP/ACCESS pair;
// o_done is high in the ACCESS cycle that the slave completes.
module spi_xip_apb_mst (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_write,
    input  logic [3:0]  i_strb,
    input  logic [2:0]  i_prot,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] o_paddr,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_pwdata,
    output logic [3:0]  o_pstrb,
    output logic [2:0]  o_pprot,
    input  logic        i_pready,
    input  logic [31:0] i_prdata,
    input  logic        i_pslverr
);

    logic [31:0] r_paddr;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_pwdata;
    logic [3:0]  r_pstrb;
    logic [2:0]  r_pprot;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_paddr   <= 32'h0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= 32'h0;
            r_pstrb   <= 4'h0;
            r_pprot   <= 3'h0;
        end else if (r_psel && r_penable) begin
            if (i_pready) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end
        end else if (r_psel) begin
            r_penable <= 1'b1;
        end else if (i_start) begin
            r_psel   <= 1'b1;
            r_paddr  <= i_addr;
            r_pwrite <= i_write;
            r_pwdata <= i_wdata;
            r_pstrb  <= i_strb;
            r_pprot  <= i_prot;
        end
    end

    assign o_done    = r_psel & r_penable & i_pready;
    assign o_rdata   = i_prdata;
    assign o_err     = i_pslverr;
    assign o_paddr   = r_paddr;
    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_pwdata  = r_pwdata;
    assign o_pstrb   = r_pstrb;
    assign o_pprot   = r_pprot;

endmodule

// File: rtl/spi_xip_ctrl.sv
// APB front end for spi_top_apb: register passthrough plus flash XIP word reads.
// Optional SPI_XIP_LASTWORD_EN keeps the most recent XIP word for repeat hits.
module spi_xip_ctrl
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] SPI_BASE   = 32'h1000_1000,
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
    parameter logic [31:0] SPI_DIV    = 32'h0000_0001,
    parameter logic [7:0]  SS_MASK    = 8'h01
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    input  logic [2:0]  in_pprot,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic [2:0]  out_pprot,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    xip_state_e  r_state;
    logic        r_in_pready;
    logic [31:0] r_in_prdata;
    logic        r_in_pslverr;
    logic [21:0] r_req_word;
    logic        r_abort;
    logic [31:0] r_rx;
    logic        r_start;
    logic [31:0] r_mst_addr;
    logic [31:0] r_mst_wdata;
    logic        r_mst_write;
    logic [3:0]  r_mst_strb;
    logic [2:0]  r_mst_prot;

    logic        w_accept;
    logic        w_hit_spi;
    logic        w_hit_flash;
    logic        w_mst_done;
    logic [31:0] w_mst_rdata;
    logic        w_mst_err;
    logic        w_lw_hit;
    logic [31:0] w_lw_data;
    xip_state_e  w_xip_next;
    logic [21:0] w_acc_word;
    logic [4:0]  w_acc_off;
    logic        w_acc_write;
    logic [31:0] w_acc_wdata;
    logic [31:0] w_acc_addr;

    assign w_accept    = (r_state == ST_IDLE) && in_psel && !in_penable;
    assign w_hit_spi   = (in_paddr[31:5] == SPI_BASE[31:5]);
    assign w_hit_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
    assign w_acc_word  = (r_state == ST_IDLE) ? in_paddr[23:2] : r_req_word;

    // Successor of the current XIP step; a slave error diverts to the SS release.
    always_comb begin
        w_xip_next = ST_WR_SSCLR;
        case (r_state)
            ST_IDLE:    w_xip_next = ST_WR_TX1;
            ST_WR_TX1:  w_xip_next = ST_WR_DIV;
            ST_WR_DIV:  w_xip_next = ST_WR_SS;
            ST_WR_SS:   w_xip_next = ST_WR_CTRL;
            ST_WR_CTRL: w_xip_next = ST_POLL;
            ST_POLL:    w_xip_next = w_mst_rdata[CTRL_GO_BIT] ? ST_POLL : ST_RD_RX;
            ST_RD_RX:   w_xip_next = ST_WR_SSCLR;
            default:    w_xip_next = ST_WR_SSCLR;
        endcase
        if (r_state != ST_IDLE && w_mst_err) begin
            w_xip_next = ST_WR_SSCLR;
        end
    end

    always_comb begin
        w_acc_off   = REG_SS;
        w_acc_write = 1'b1;
        w_acc_wdata = 32'h0;
        case (w_xip_next)
            ST_WR_TX1: begin
                w_acc_off   = REG_TX1;
                w_acc_wdata = {FLASH_READ_OP, w_acc_word, 2'b00};
            end
            ST_WR_DIV: begin
                w_acc_off   = REG_DIVIDER;
                w_acc_wdata = SPI_DIV;
            end
            ST_WR_SS: begin
                w_acc_off   = REG_SS;
                w_acc_wdata = {24'd0, SS_MASK};
            end
            ST_WR_CTRL: begin
                w_acc_off   = REG_CTRL;
                w_acc_wdata = XIP_CTRL;
            end
            ST_POLL: begin
                w_acc_off   = REG_CTRL;
                w_acc_write = 1'b0;
            end
            ST_RD_RX: begin
                w_acc_off   = REG_RX0;
                w_acc_write = 1'b0;
            end
            default: begin
                w_acc_off   = REG_SS;
                w_acc_wdata = 32'h0;
            end
        endcase
    end

    assign w_acc_addr = SPI_BASE + {27'd0, w_acc_off};

`ifdef SPI_XIP_LASTWORD_EN
    logic        r_lw_valid;
    logic [29:0] r_lw_word;
    logic [31:0] r_lw_data;
    logic [7:0]  r_req_tag;
    logic        w_lw_fill;
    logic        w_lw_inval;

    assign w_lw_fill  = (r_state == ST_WR_SSCLR) && w_mst_done && !r_abort && !w_mst_err;
    assign w_lw_inval = w_accept && w_hit_spi && in_pwrite;
    assign w_lw_hit   = r_lw_valid && (r_lw_word == in_paddr[31:2]);
    assign w_lw_data  = r_lw_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lw_valid <= 1'b0;
            r_lw_word  <= 30'h0;
            r_lw_data  <= 32'h0;
            r_req_tag  <= 8'h0;
        end else begin
            if (w_accept) begin
                r_req_tag <= in_paddr[31:24];
            end
            if (w_lw_inval) begin
                r_lw_valid <= 1'b0;
            end else if (w_lw_fill) begin
                r_lw_valid <= 1'b1;
                r_lw_word  <= {r_req_tag, r_req_word};
                r_lw_data  <= r_rx;
            end
        end
    end
`else
    assign w_lw_hit  = 1'b0;
    assign w_lw_data = 32'h0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_in_pready  <= 1'b0;
            r_in_prdata  <= 32'h0;
            r_in_pslverr <= 1'b0;
            r_req_word   <= 22'h0;
            r_abort      <= 1'b0;
            r_rx         <= 32'h0;
            r_start      <= 1'b0;
            r_mst_addr   <= 32'h0;
            r_mst_wdata  <= 32'h0;
            r_mst_write  <= 1'b0;
            r_mst_strb   <= 4'h0;
            r_mst_prot   <= 3'h0;
        end else begin
            r_start      <= 1'b0;
            r_in_pready  <= 1'b0;
            r_in_pslverr <= 1'b0;
            r_in_prdata  <= 32'h0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_word <= in_paddr[23:2];
                        r_abort    <= 1'b0;
                        if (w_hit_spi) begin
                            r_state     <= ST_PASS;
                            r_start     <= 1'b1;
                            r_mst_addr  <= in_paddr;
                            r_mst_wdata <= in_pwdata;
                            r_mst_write <= in_pwrite;
                            r_mst_strb  <= in_pstrb;
                            r_mst_prot  <= in_pprot;
                        end else if (w_hit_flash && !in_pwrite) begin
                            if (w_lw_hit) begin
                                r_state     <= ST_RESP;
                                r_in_pready <= 1'b1;
                                r_in_prdata <= byte_swap(w_lw_data);
                            end else begin
                                r_state     <= w_xip_next;
                                r_start     <= 1'b1;
                                r_mst_addr  <= w_acc_addr;
                                r_mst_wdata <= w_acc_wdata;
                                r_mst_write <= w_acc_write;
                                r_mst_strb  <= 4'hf;
                                r_mst_prot  <= 3'h0;
                            end
                        end else begin
                            r_state      <= ST_ERR;
                            r_in_pready  <= 1'b1;
                            r_in_pslverr <= 1'b1;
                        end
                    end
                end
                ST_PASS: begin
                    if (w_mst_done) begin
                        r_state      <= ST_RESP;
                        r_in_pready  <= 1'b1;
                        r_in_prdata  <= w_mst_rdata;
                        r_in_pslverr <= w_mst_err;
                    end
                end
                ST_ERR, ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    if (w_mst_done) begin
                        if (r_state == ST_RD_RX) begin
                            r_rx <= w_mst_rdata;
                        end
                        if (r_state == ST_WR_SSCLR) begin
                            r_state     <= ST_RESP;
                            r_in_pready <= 1'b1;
                            if (r_abort || w_mst_err) begin
                                r_in_pslverr <= 1'b1;
                            end else begin
                                r_in_prdata <= byte_swap(r_rx);
                            end
                        end else begin
                            if (w_mst_err) begin
                                r_abort <= 1'b1;
                            end
                            r_state     <= w_xip_next;
                            r_start     <= 1'b1;
                            r_mst_addr  <= w_acc_addr;
                            r_mst_wdata <= w_acc_wdata;
                            r_mst_write <= w_acc_write;
                            r_mst_strb  <= 4'hf;
                            r_mst_prot  <= 3'h0;
                        end
                    end
                end
            endcase
        end
    end

    assign in_pready  = r_in_pready;
    assign in_prdata  = r_in_prdata;
    assign in_pslverr = r_in_pslverr;

    spi_xip_apb_mst u_mst (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_start   (r_start),
        .i_addr    (r_mst_addr),
        .i_wdata   (r_mst_wdata),
        .i_write   (r_mst_write),
        .i_strb    (r_mst_strb),
        .i_prot    (r_mst_prot),
        .o_done    (w_mst_done),
        .o_rdata   (w_mst_rdata),
        .o_err     (w_mst_err),
        .o_paddr   (out_paddr),
        .o_psel    (out_psel),
        .o_penable (out_penable),
        .o_pwrite  (out_pwrite),
        .o_pwdata  (out_pwdata),
        .o_pstrb   (out_pstrb),
        .o_pprot   (out_pprot),
        .i_pready  (out_pready),
        .i_prdata  (out_prdata),
        .i_pslverr (out_pslverr)
    );

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Directed bench for spi_xip_ctrl with a small behavioural spi_top_apb register model.
// Build with SPI_XIP_LASTWORD_EN defined to exercise the last-word buffer checks.
module tb_spi_xip_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_paddr = 32'h0;
    logic        in_psel = 1'b0;
    logic        in_penable = 1'b0;
    logic        in_pwrite = 1'b0;
    logic [31:0] in_pwdata = 32'h0;
    logic [3:0]  in_pstrb = 4'hf;
    logic [2:0]  in_pprot = 3'h0;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic [2:0]  out_pprot;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    int n_vec = 0;
    int n_mis = 0;

    // SPI register model state
    logic [31:0] rx_val = 32'h0;
    int          go_cfg = 0;
    int          go_cnt = 0;
    logic        err_en = 1'b0;
    logic [4:0]  err_off = 5'h0;
    logic        err_wr = 1'b0;
    logic [31:0] lg_addr [512];
    logic        lg_wr   [512];
    logic [31:0] lg_data [512];
    int          lg_n = 0;
    int          psel_cycles = 0;

    always #5 clock = ~clock;

    spi_xip_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_paddr    (in_paddr),
        .in_psel     (in_psel),
        .in_penable  (in_penable),
        .in_pwrite   (in_pwrite),
        .in_pwdata   (in_pwdata),
        .in_pstrb    (in_pstrb),
        .in_pprot    (in_pprot),
        .in_pready   (in_pready),
        .in_prdata   (in_prdata),
        .in_pslverr  (in_pslverr),
        .out_paddr   (out_paddr),
        .out_psel    (out_psel),
        .out_penable (out_penable),
        .out_pwrite  (out_pwrite),
        .out_pwdata  (out_pwdata),
        .out_pstrb   (out_pstrb),
        .out_pprot   (out_pprot),
        .out_pready  (out_pready),
        .out_prdata  (out_prdata),
        .out_pslverr (out_pslverr)
    );

    assign out_pready  = out_psel & out_penable;
    assign out_pslverr = out_psel & out_penable & err_en &
                         (out_paddr[4:0] == err_off) & (out_pwrite == err_wr);

    always_comb begin
        out_prdata = 32'h0;
        case (out_paddr[4:0])
            5'h00:   out_prdata = rx_val;
            5'h10:   out_prdata = (go_cnt > 0) ? 32'h0000_2540 : 32'h0000_2440;
            default: out_prdata = 32'h0;
        endcase
    end

    always @(posedge clock) begin
        if (out_psel) psel_cycles = psel_cycles + 1;
        if (out_psel && out_penable) begin
            if (lg_n < 512) begin
                lg_addr[lg_n] = out_paddr;
                lg_wr[lg_n]   = out_pwrite;
                lg_data[lg_n] = out_pwdata;
            end
            lg_n = lg_n + 1;
            if (out_paddr[4:0] == 5'h10) begin
                if (out_pwrite && out_pwdata[8]) go_cnt = go_cfg;
                else if (!out_pwrite && go_cnt > 0) go_cnt = go_cnt - 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic cpu_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output logic er, output int lat);
        @(posedge clock); #1;
        in_paddr = a; in_pwrite = w; in_pwdata = d; in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock); #1;
        in_penable = 1'b1;
        lat = 2;
        while (!in_pready && lat < 300) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!in_pready) check_val("cpu_timeout", {31'b0, in_pready}, 32'h1);
        rd = in_prdata;
        er = in_pslverr;
        @(posedge clock); #1;
        in_psel = 1'b0; in_penable = 1'b0;
        check_val("pready_one_cycle", {31'b0, in_pready}, 32'h0);
    endtask

    task automatic check_acc(input string tag, input int idx, input logic [31:0] a,
                             input logic w, input logic [31:0] d);
        check_val({tag, "_addr"}, lg_addr[idx], a);
        check_val({tag, "_wr"}, {31'b0, lg_wr[idx]}, {31'b0, w});
        if (w) check_val({tag, "_wdata"}, lg_data[idx], d);
    endtask

    // Expected XIP downstream order with np extra polls of CTRL.
    task automatic check_seq(input string tag, input int base, input logic [31:0] tx1, input int np);
        check_acc({tag, "_tx1"},  base + 0, 32'h1000_1004, 1'b1, tx1);
        check_acc({tag, "_div"},  base + 1, 32'h1000_1014, 1'b1, 32'h1);
        check_acc({tag, "_ss"},   base + 2, 32'h1000_1018, 1'b1, 32'h1);
        check_acc({tag, "_ctrl"}, base + 3, 32'h1000_1010, 1'b1, 32'h2540);
        for (int i = 0; i <= np; i++)
            check_acc($sformatf("%s_poll%0d", tag, i), base + 4 + i, 32'h1000_1010, 1'b0, 32'h0);
        check_acc({tag, "_rx"},    base + 5 + np, 32'h1000_1000, 1'b0, 32'h0);
        check_acc({tag, "_sscl"},  base + 6 + np, 32'h1000_1018, 1'b1, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          base;
        int          pbase;
        logic        found;

        repeat (3) @(posedge clock);
        #1;
        check_val("rst_ctl", {27'b0, in_pready, in_pslverr, out_psel, out_penable, out_pwrite}, 32'h0);
        check_val("rst_in_prdata", in_prdata, 32'h0);
        check_val("rst_out_paddr", out_paddr, 32'h0);
        check_val("rst_out_misc", {25'b0, out_pstrb, out_pprot}, 32'h0);
        reset_n = 1'b1;

        // Basic XIP read
        rx_val = 32'h1122_3344; go_cfg = 0; base = lg_n;
        cpu_xfer(32'h3000_0010, 1'b0, 32'h0, rd, er, lat);
        check_val("xip_rdata", rd, 32'h4433_2211);
        check_val("xip_err", {31'b0, er}, 32'h0);
        check_val("xip_nacc", lg_n - base, 32'd7);
        check_seq("xip", base, 32'h0300_0010, 0);

        // Passthrough write and read
        base = lg_n;
        cpu_xfer(32'h1000_1014, 1'b1, 32'h5, rd, er, lat);
        check_val("pass_wr_err", {31'b0, er}, 32'h0);
        check_val("pass_wr_nacc", lg_n - base, 32'd1);
        check_acc("pass_wr", base, 32'h1000_1014, 1'b1, 32'h5);
        base = lg_n;
        cpu_xfer(32'h1000_1000, 1'b0, 32'h0, rd, er, lat);
        check_val("pass_rd_data", rd, 32'h1122_3344);
        check_val("pass_rd_nacc", lg_n - base, 32'd1);

        // GO held for three extra polls
        rx_val = 32'hA1B2_C3D4; go_cfg = 3; base = lg_n;
        cpu_xfer(32'h30AB_CDEC, 1'b0, 32'h0, rd, er, lat);
        check_val("poll_rdata", rd, 32'hD4C3_B2A1);
        check_val("poll_nacc", lg_n - base, 32'd10);
        check_seq("poll", base, 32'h03AB_CDEC, 3);
        go_cfg = 0;

        // Decode errors: flash write, unmapped read
        base = lg_n; pbase = psel_cycles;
        cpu_xfer(32'h3000_0000, 1'b1, 32'h1234, rd, er, lat);
        check_val("errw_slverr", {31'b0, er}, 32'h1);
        check_val("errw_rdata", rd, 32'h0);
        check_val("errw_lat", lat, 32'd2);
        cpu_xfer(32'h2000_0000, 1'b0, 32'h0, rd, er, lat);
        check_val("erru_slverr", {31'b0, er}, 32'h1);
        check_val("erru_lat", lat, 32'd2);
        check_val("err_no_psel", psel_cycles - pbase, 32'd0);
        check_val("err_no_acc", lg_n - base, 32'd0);

        // Slave error on CTRL write aborts to SS release
        err_en = 1'b1; err_off = 5'h10; err_wr = 1'b1; base = lg_n;
        cpu_xfer(32'h3000_0040, 1'b0, 32'h0, rd, er, lat);
        err_en = 1'b0;
        check_val("abort_slverr", {31'b0, er}, 32'h1);
        check_val("abort_rdata", rd, 32'h0);
        check_val("abort_nacc", lg_n - base, 32'd5);
        check_acc("abort_ctrl", base + 3, 32'h1000_1010, 1'b1, 32'h2540);
        check_acc("abort_sscl", base + 4, 32'h1000_1018, 1'b1, 32'h0);

        // Reset asserted while polling
        go_cfg = 1000; found = 1'b0;
        @(posedge clock); #1;
        in_paddr = 32'h3000_0020; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock); #1;
        in_penable = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clock); #1;
            if (out_psel && !out_pwrite && out_paddr == 32'h1000_1010) found = 1'b1;
        end
        check_val("rstpoll_seen", {31'b0, found}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_val("rstpoll_ctl", {27'b0, in_pready, in_pslverr, out_psel, out_penable, out_pwrite}, 32'h0);
        check_val("rstpoll_prdata", in_prdata, 32'h0);
        check_val("rstpoll_paddr", out_paddr, 32'h0);
        check_val("rstpoll_pwdata", out_pwdata, 32'h0);
        in_psel = 1'b0; in_penable = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1; go_cfg = 0;
        rx_val = 32'h1122_3344; base = lg_n;
        cpu_xfer(32'h3000_0010, 1'b0, 32'h0, rd, er, lat);
        check_val("postrst_rdata", rd, 32'h4433_2211);
        check_val("postrst_nacc", lg_n - base, 32'd7);

        // Repeated read of one word, then invalidation by a passthrough write
        rx_val = 32'hCAFE_F00D; base = lg_n;
        cpu_xfer(32'h3000_0100, 1'b0, 32'h0, rd, er, lat);
        check_val("lw1_rdata", rd, 32'h0DF0_FECA);
        check_val("lw1_nacc", lg_n - base, 32'd7);
        rx_val = 32'h0; base = lg_n;
        cpu_xfer(32'h3000_0100, 1'b0, 32'h0, rd, er, lat);
`ifdef SPI_XIP_LASTWORD_EN
        check_val("lw2_rdata", rd, 32'h0DF0_FECA);
        check_val("lw2_nacc", lg_n - base, 32'd0);
        check_val("lw2_lat", lat, 32'd2);
`else
        check_val("lw2_rdata", rd, 32'h0);
        check_val("lw2_nacc", lg_n - base, 32'd7);
`endif
        cpu_xfer(32'h1000_1014, 1'b1, 32'h1, rd, er, lat);
        rx_val = 32'h0102_0304; base = lg_n;
        cpu_xfer(32'h3000_0100, 1'b0, 32'h0, rd, er, lat);
        check_val("lw3_rdata", rd, 32'h0403_0201);
        check_val("lw3_nacc", lg_n - base, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
